// File: rtl/kmeans_centroid_update.sv
// k-means update stage: accumulates per-cluster sums/counts of 4-D points over an
// epoch, then divides each sum by its count with one shared restoring divider.
module kmeans_centroid_update #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic [DATA_W-1:0] data_in3,
   input  logic [DATA_W-1:0] data_in4,
   input  logic [1:0]        cluster_addr,
   input  logic              epoch_end,
   output logic [DATA_W-1:0] centroid1_1,
   output logic [DATA_W-1:0] centroid1_2,
   output logic [DATA_W-1:0] centroid1_3,
   output logic [DATA_W-1:0] centroid1_4,
   output logic [DATA_W-1:0] centroid2_1,
   output logic [DATA_W-1:0] centroid2_2,
   output logic [DATA_W-1:0] centroid2_3,
   output logic [DATA_W-1:0] centroid2_4,
   output logic [DATA_W-1:0] centroid3_1,
   output logic [DATA_W-1:0] centroid3_2,
   output logic [DATA_W-1:0] centroid3_3,
   output logic [DATA_W-1:0] centroid3_4,
   output logic              cent_valid,
   output logic [2:0]        empty_mask,
   output logic              addr_err,
   output logic              cnt_sat,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;
   localparam int STEP_W = $clog2(ACC_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state_q, state_d;
   logic [2:0][3:0][ACC_W-1:0]  acc_q, acc_d;
   logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0][3:0][DATA_W-1:0] cent_q, cent_d, shadow_q, shadow_d;
   logic [2:0]                  empty_q, empty_d;
   logic                        addr_err_q, addr_err_d, cnt_sat_q, cnt_sat_d;
   logic                        cent_valid_q, cent_valid_d, in_ready_q, in_ready_d;
   logic                        busy_q, busy_d;
   logic [1:0]                  cl_q, cl_d, dim_q, dim_d;
   logic [STEP_W-1:0]           step_q, step_d;
   logic [ACC_W-1:0]            quo_q, quo_d, quo_nx;
   logic [CNT_W-1:0]            rem_q, rem_d, divisor;
   logic [CNT_W:0]              rem_sh, rem_nx;
   logic                        q_bit;
   logic [3:0][DATA_W-1:0]      din;

   assign din = {data_in4, data_in3, data_in2, data_in1};

   // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
   always_comb begin
      divisor = cnt_q[cl_q];
      rem_sh  = {rem_q, quo_q[ACC_W-1]};
      q_bit   = (rem_sh >= {1'b0, divisor});
      rem_nx  = q_bit ? (rem_sh - {1'b0, divisor}) : rem_sh;
      quo_nx  = {quo_q[ACC_W-2:0], q_bit};
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      cent_d       = cent_q;
      shadow_d     = shadow_q;
      empty_d      = empty_q;
      addr_err_d   = addr_err_q;
      cnt_sat_d    = cnt_sat_q;
      cent_valid_d = 1'b0;
      cl_d         = cl_q;
      dim_d        = dim_q;
      step_d       = step_q;
      quo_d        = quo_q;
      rem_d        = rem_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = ACCUM;
               acc_d      = '0;
               cnt_d      = '0;
               addr_err_d = 1'b0;
               cnt_sat_d  = 1'b0;
            end
         end
         ACCUM: begin
            if (start) begin
               acc_d      = '0;
               cnt_d      = '0;
               addr_err_d = 1'b0;
               cnt_sat_d  = 1'b0;
            end else begin
               if (in_valid && in_ready_q) begin
                  if (cluster_addr == 2'd3) addr_err_d = 1'b1;
                  for (int k = 0; k < 3; k++) begin
                     if (cluster_addr == 2'(k)) begin
                        if (cnt_q[k] == CNT_MAX) begin
                           cnt_sat_d = 1'b1;
                        end else begin
                           cnt_d[k] = cnt_q[k] + CNT_W'(1);
                           for (int d = 0; d < 4; d++)
                              acc_d[k][d] = acc_q[k][d] + ACC_W'(din[d]);
                        end
                     end
                  end
               end
               if (epoch_end) begin
                  state_d = DIVIDE;
                  cl_d    = 2'd0;
                  dim_d   = 2'd0;
                  step_d  = '0;
               end
            end
         end
         DIVIDE: begin
            if (step_q == '0) begin
               quo_d  = acc_q[cl_q][dim_q];
               rem_d  = '0;
               step_d = STEP_W'(1);
            end else begin
               quo_d = quo_nx;
               rem_d = CNT_W'(rem_nx);
               if (step_q == STEP_W'(ACC_W)) begin
                  step_d = '0;
                  // Empty clusters still burn their slots so latency stays fixed.
                  if (divisor != '0) shadow_d[cl_q][dim_q] = quo_nx[DATA_W-1:0];
                  if (dim_q == 2'd3) begin
                     dim_d = 2'd0;
                     if (cl_q == 2'd2) state_d = DONE;
                     else              cl_d    = cl_q + 2'd1;
                  end else begin
                     dim_d = dim_q + 2'd1;
                  end
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         DONE: begin
            for (int k = 0; k < 3; k++) begin
               empty_d[k] = (cnt_q[k] == '0);
               if (cnt_q[k] != '0) cent_d[k] = shadow_q[k];
            end
            cent_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == ACCUM);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         cent_q       <= '0;
         shadow_q     <= '0;
         empty_q      <= '0;
         addr_err_q   <= 1'b0;
         cnt_sat_q    <= 1'b0;
         cent_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         cl_q         <= '0;
         dim_q        <= '0;
         step_q       <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         cent_q       <= cent_d;
         shadow_q     <= shadow_d;
         empty_q      <= empty_d;
         addr_err_q   <= addr_err_d;
         cnt_sat_q    <= cnt_sat_d;
         cent_valid_q <= cent_valid_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         cl_q         <= cl_d;
         dim_q        <= dim_d;
         step_q       <= step_d;
         quo_q        <= quo_d;
         rem_q        <= rem_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign cent_valid  = cent_valid_q;
   assign empty_mask  = empty_q;
   assign addr_err    = addr_err_q;
   assign cnt_sat     = cnt_sat_q;
   assign busy        = busy_q;
   assign centroid1_1 = cent_q[0][0];
   assign centroid1_2 = cent_q[0][1];
   assign centroid1_3 = cent_q[0][2];
   assign centroid1_4 = cent_q[0][3];
   assign centroid2_1 = cent_q[1][0];
   assign centroid2_2 = cent_q[1][1];
   assign centroid2_3 = cent_q[1][2];
   assign centroid2_4 = cent_q[1][3];
   assign centroid3_1 = cent_q[2][0];
   assign centroid3_2 = cent_q[2][1];
   assign centroid3_3 = cent_q[2][2];
   assign centroid3_4 = cent_q[2][3];
endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Bench for kmeans_centroid_update: a default build and a CNT_W=2 build share stimulus;
// a point-list/mean model predicts every output each cycle, literals pin the model.
module tb_kmeans_centroid_update;
   localparam int ACC_W = 32;
   localparam int LAT   = 12 * (ACC_W + 1) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, in_valid, epoch_end;
   logic [15:0] d1, d2, d3, d4;
   logic [1:0]  addr;
   logic [1:0]  rdy, cv, aerr, sat, busy;
   logic [1:0][2:0] mask;
   logic [1:0][2:0][3:0][15:0] cen;

   kmeans_centroid_update #(.DATA_W(16), .ACC_W(ACC_W), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
      .data_in1(d1), .data_in2(d2), .data_in3(d3), .data_in4(d4),
      .cluster_addr(addr), .epoch_end(epoch_end),
      .centroid1_1(cen[0][0][0]), .centroid1_2(cen[0][0][1]), .centroid1_3(cen[0][0][2]), .centroid1_4(cen[0][0][3]),
      .centroid2_1(cen[0][1][0]), .centroid2_2(cen[0][1][1]), .centroid2_3(cen[0][1][2]), .centroid2_4(cen[0][1][3]),
      .centroid3_1(cen[0][2][0]), .centroid3_2(cen[0][2][1]), .centroid3_3(cen[0][2][2]), .centroid3_4(cen[0][2][3]),
      .cent_valid(cv[0]), .empty_mask(mask[0]), .addr_err(aerr[0]), .cnt_sat(sat[0]), .busy(busy[0]));

   kmeans_centroid_update #(.DATA_W(16), .ACC_W(ACC_W), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
      .data_in1(d1), .data_in2(d2), .data_in3(d3), .data_in4(d4),
      .cluster_addr(addr), .epoch_end(epoch_end),
      .centroid1_1(cen[1][0][0]), .centroid1_2(cen[1][0][1]), .centroid1_3(cen[1][0][2]), .centroid1_4(cen[1][0][3]),
      .centroid2_1(cen[1][1][0]), .centroid2_2(cen[1][1][1]), .centroid2_3(cen[1][1][2]), .centroid2_4(cen[1][1][3]),
      .centroid3_1(cen[1][2][0]), .centroid3_2(cen[1][2][1]), .centroid3_3(cen[1][2][2]), .centroid3_4(cen[1][2][3]),
      .cent_valid(cv[1]), .empty_mask(mask[1]), .addr_err(aerr[1]), .cnt_sat(sat[1]), .busy(busy[1]));

   int nchk = 0, nerr = 0, cyc = 0, due = 0, eoe_cyc = 0;
   bit chk_on = 0, accum = 0;
   longint sum [2][3][4];
   int     cnt [2][3];
   int     maxc [2] = '{65535, 3};
   logic [15:0] exp_cent [2][3][4];
   logic [15:0] pend [2][3][4];
   logic [2:0]  exp_mask [2], pend_mask [2];
   bit          exp_aerr [2], exp_sat [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int m = 0; m < 2; m++) begin
         exp_aerr[m] = 0; exp_sat[m] = 0;
         for (int k = 0; k < 3; k++) begin
            cnt[m][k] = 0;
            for (int d = 0; d < 4; d++) sum[m][k][d] = 0;
         end
      end
   endtask

   task automatic model_reset();
      model_clear();
      accum = 0; due = 0;
      for (int m = 0; m < 2; m++) begin
         exp_mask[m] = '0; pend_mask[m] = '0;
         for (int k = 0; k < 3; k++)
            for (int d = 0; d < 4; d++) exp_cent[m][k][d] = '0;
      end
   endtask

   // One clock of stimulus; the model then folds in what the block saw at that edge.
   task automatic drive(input bit st, input bit v, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] e, input logic [1:0] ad,
                        input bit eoe, input bit rst);
      logic [15:0] p [4];
      p[0] = a; p[1] = b; p[2] = c; p[3] = e;
      reset = rst; start = st; in_valid = v; d1 = a; d2 = b; d3 = c; d4 = e;
      addr = ad; epoch_end = eoe;
      @(posedge clk); #1;
      if (rst) model_reset();
      else if (accum) begin
         if (st) model_clear();
         else begin
            if (v) for (int m = 0; m < 2; m++) begin
               if (ad == 2'd3) exp_aerr[m] = 1;
               else if (cnt[m][ad] == maxc[m]) exp_sat[m] = 1;
               else begin
                  cnt[m][ad]++;
                  for (int d = 0; d < 4; d++) sum[m][ad][d] += p[d];
               end
            end
            if (eoe) begin
               for (int m = 0; m < 2; m++)
                  for (int k = 0; k < 3; k++) begin
                     pend_mask[m][k] = (cnt[m][k] == 0);
                     if (cnt[m][k] != 0)
                        for (int d = 0; d < 4; d++) pend[m][k][d] = 16'(sum[m][k][d] / cnt[m][k]);
                  end
               accum = 0; due = cyc + LAT; eoe_cyc = cyc;
            end
         end
      end else if (cyc > due && st) begin
         accum = 1; model_clear();
      end
      reset = 0; start = 0; in_valid = 0; epoch_end = 0;
   endtask

   task automatic pt(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                     input logic [15:0] e, input logic [1:0] ad);
      drive(0, 1, a, b, c, e, ad, 0, 0);
   endtask
   task automatic go();  drive(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic eoe(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic basic(input bit bad);
      pt(5100, 3500, 1400, 200, 0);
      pt(7000, 3200, 4700, 1400, 1);
      if (bad) pt(100, 100, 100, 100, 3);
      pt(4900, 3000, 1400, 200, 0);
      pt(6400, 3200, 4500, 1500, 1);
      pt(6900, 3100, 4900, 1500, 1);
   endtask

   task automatic wait_cv(input string nm);
      int lat;
      lat = -1;
      for (int i = 0; i < LAT + 50; i++) begin
         @(negedge clk);
         if (cv[0]) begin lat = cyc - eoe_cyc; break; end
      end
      chk({nm, "_latency"}, lat, 397);
   endtask

   task automatic chk_vec(input string nm, input int m, input int k, input int a, input int b,
                          input int c, input int e);
      chk({nm, "_1"}, cen[m][k][0], a);
      chk({nm, "_2"}, cen[m][k][1], b);
      chk({nm, "_3"}, cen[m][k][2], c);
      chk({nm, "_4"}, cen[m][k][3], e);
   endtask

   task automatic chk_basic(input string nm);
      chk_vec({nm, "_c1"}, 0, 0, 5000, 3250, 1400, 200);
      chk_vec({nm, "_c2"}, 0, 1, 6766, 3166, 4700, 1466);
   endtask

   // Cycle-by-cycle comparison of both builds against the model.
   always @(negedge clk) if (chk_on) begin
      if (cyc == due)
         for (int m = 0; m < 2; m++) begin
            exp_mask[m] = pend_mask[m];
            for (int k = 0; k < 3; k++)
               if (!pend_mask[m][k])
                  for (int d = 0; d < 4; d++) exp_cent[m][k][d] = pend[m][k][d];
         end
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("cent_valid%0d", m), cv[m], longint'(cyc == due));
         chk($sformatf("busy%0d", m), busy[m], longint'(accum || cyc < due));
         chk($sformatf("in_ready%0d", m), rdy[m], longint'(accum));
         chk($sformatf("empty_mask%0d", m), mask[m], exp_mask[m]);
         chk($sformatf("addr_err%0d", m), aerr[m], exp_aerr[m]);
         chk($sformatf("cnt_sat%0d", m), sat[m], exp_sat[m]);
         for (int k = 0; k < 3; k++)
            for (int d = 0; d < 4; d++)
               chk($sformatf("centroid%0d_%0d_%0d", m, k + 1, d + 1), cen[m][k][d], exp_cent[m][k][d]);
      end
   end

   initial begin
      int pulses;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk_on = 1;
      idle(2);
      chk_vec("reset_c1", 0, 0, 0, 0, 0, 0);
      chk("reset_in_ready", rdy[0], 0);

      go(); basic(0); eoe(); wait_cv("basic");
      chk_basic("basic");
      chk_vec("basic_c3", 0, 2, 0, 0, 0, 0);
      chk("basic_mask", mask[0], 3'b100);
      idle(3);

      go(); pt(6300, 3300, 6000, 2500, 2); eoe(); wait_cv("retain");
      chk_vec("retain_c3", 0, 2, 6300, 3300, 6000, 2500);
      chk_basic("retain");
      chk("retain_mask", mask[0], 3'b011);
      idle(2);

      go(); drive(0, 1, 7200, 3600, 6100, 2500, 2, 1, 0); wait_cv("same_cycle");
      chk_vec("same_cycle_c3", 0, 2, 7200, 3600, 6100, 2500);
      idle(2);

      go(); basic(1); eoe(); wait_cv("illegal");
      chk_basic("illegal");
      chk("illegal_addr_err", aerr[0], 1);
      idle(2);
      chk("illegal_addr_err_sticky", aerr[0], 1);
      go();
      @(negedge clk);
      chk("illegal_addr_err_cleared", aerr[0], 0);

      basic(0); eoe(); idle(50);
      drive(1, 1, 1, 1, 1, 1, 0, 0, 0);
      chk("start_in_divide_in_ready", rdy[0], 0);
      wait_cv("start_in_divide");
      chk_basic("start_in_divide");
      idle(2);

      go(); basic(0); eoe(); idle(100);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      pulses = 0;
      for (int i = 0; i < LAT + 20; i++) begin
         @(negedge clk);
         if (cv[0]) pulses++;
      end
      chk("reset_abort_pulses", pulses, 0);
      chk_vec("reset_abort_c2", 0, 1, 0, 0, 0, 0);
      chk("reset_abort_busy", busy[0], 0);
      chk("reset_abort_in_ready", rdy[0], 0);

      go();
      for (int i = 0; i < 5; i++) pt(400, 400, 400, 400, 0);
      eoe(); wait_cv("sat");
      chk("sat_flag_small", sat[1], 1);
      chk("sat_flag_wide", sat[0], 0);
      chk_vec("sat_c1_small", 1, 0, 400, 400, 400, 400);
      chk_vec("sat_c1_wide", 0, 0, 400, 400, 400, 400);
      idle(2);

      chk_on = 0;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
